// File: rtl/itype_ctrl.sv
// Multicycle I-type control FSM: fetch/decode/exec/mem/wb, ALU ops 4 cycles, lw 5, sw 4, branch 3.
// Stalls in MEM until mem_ready; traps on unsupported opcodes until reset.
module itype_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_branch,
    output logic             ext_sel,
    output logic [2:0]       alu_ctl,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_LUI = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           state_q;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0] op_alu;
    logic       op_ext;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LW, OP_SW, OP_BEQ, OP_BNE: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // ALU control and extender select for the latched opcode
    always_comb begin
        op_alu = ALU_ADD;
        op_ext = 1'b0;
        case (op_q)
            OP_SLTI:          op_alu = ALU_SLT;
            OP_ANDI: begin    op_alu = ALU_AND; op_ext = 1'b1; end
            OP_ORI:  begin    op_alu = ALU_OR;  op_ext = 1'b1; end
            OP_XORI: begin    op_alu = ALU_XOR; op_ext = 1'b1; end
            OP_LUI:           op_alu = ALU_LUI;
            OP_BEQ, OP_BNE:   op_alu = ALU_SUB;
            default:          op_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_branch  = 1'b0;
        ext_sel    = 1'b0;
        alu_ctl    = 3'b000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
            end
            S_EXEC: begin
                alu_ctl = op_alu;
                ext_sel = op_ext;
            end
            S_MEM: begin
                alu_ctl   = ALU_ADD;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                retire    = (op_q == OP_SW) && mem_ready;
            end
            S_WB: begin
                alu_ctl    = op_alu;
                ext_sel    = op_ext;
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LW);
                retire     = 1'b1;
            end
            S_BRANCH: begin
                alu_ctl   = ALU_SUB;
                pc_branch = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
                retire    = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 6'd0;
            cnt_q   <= '0;
        end else begin
            if (retire)
                cnt_q <= cnt_q + 1'b1;
            case (state_q)
                S_IDLE:   if (run) state_q <= S_FETCH;
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    if (!op_legal(opcode))
                        state_q <= S_TRAP;
                    else if (opcode == OP_BEQ || opcode == OP_BNE)
                        state_q <= S_BRANCH;
                    else
                        state_q <= S_EXEC;
                end
                S_EXEC:   state_q <= (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
                S_MEM: begin
                    if (mem_ready) begin
                        if (op_q == OP_LW)
                            state_q <= S_WB;
                        else
                            state_q <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_WB, S_BRANCH: state_q <= run ? S_FETCH : S_IDLE;
                S_TRAP:   state_q <= S_TRAP;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_itype_ctrl.sv
// Randomized bench for itype_ctrl: stimulus pushes expected per-cycle outputs, a negedge monitor compares.
module tb_itype_ctrl;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, run, zero, mem_ready;
    logic [5:0]    opcode;
    logic          ir_write, pc_write, pc_branch, ext_sel;
    logic [2:0]    alu_ctl;
    logic          mem_read, mem_write, mem_to_reg, reg_write, retire, illegal;
    logic [CW-1:0] retired_cnt;

    always #5 clk = ~clk;

    itype_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .pc_branch(pc_branch), .ext_sel(ext_sel), .alu_ctl(alu_ctl),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .retire(retire), .illegal(illegal),
        .retired_cnt(retired_cnt)
    );

    typedef struct packed {
        logic [12:0]   v;
        logic [CW-1:0] c;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] cnt_m = '0;
    bit            in_idle = 1'b1;

    wire [12:0] dut_v = {ir_write, pc_write, pc_branch, ext_sel, alu_ctl,
                         mem_read, mem_write, mem_to_reg, reg_write, retire, illegal};

    function automatic logic [12:0] mk(input logic ir, pcw, pcb, ext, input logic [2:0] alu,
                                       input logic mr, mw, m2r, rw, ret, ill);
        return {ir, pcw, pcb, ext, alu, mr, mw, m2r, rw, ret, ill};
    endfunction

    // Instruction class from the opcode table: 0 ALU, 1 lw, 2 sw, 3 branch, 4 illegal
    function automatic int classify(input logic [5:0] op, output logic [2:0] alu, output logic ext);
        alu = 3'b010; ext = 1'b0;
        case (op)
            6'b001000, 6'b001001: return 0;
            6'b001010: begin alu = 3'b111; return 0; end
            6'b001100: begin alu = 3'b000; ext = 1'b1; return 0; end
            6'b001101: begin alu = 3'b001; ext = 1'b1; return 0; end
            6'b001110: begin alu = 3'b011; ext = 1'b1; return 0; end
            6'b001111: begin alu = 3'b100; return 0; end
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000100, 6'b000101: begin alu = 3'b110; return 3; end
            default:   return 4;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (dut_v !== e.v) begin
                errors++;
                $display("FAIL outputs t=%0t got %b exp %b", $time, dut_v, e.v);
            end
            checks++;
            if (retired_cnt !== e.c) begin
                errors++;
                $display("FAIL retired_cnt t=%0t got %0d exp %0d", $time, retired_cnt, e.c);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] ro();
        return 6'($urandom);
    endfunction

    task automatic cyc(input logic r, input logic [5:0] op, input logic z, input logic mr,
                       input logic [12:0] v);
        run = r; opcode = op; zero = z; mem_ready = mr;
        exp_q.push_back({v, cnt_m});
        if (v[1]) cnt_m = cnt_m + 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic start_if_idle();
        if (in_idle) begin
            if (rb()) cyc(1'b0, ro(), rb(), rb(), 13'd0);
            cyc(1'b1, ro(), rb(), rb(), 13'd0);
        end
    endtask

    task automatic instr(input logic [5:0] op, input int s, input logic zb, input logic run_after);
        logic [2:0] a;
        logic       e;
        int         k;
        k = classify(op, a, e);
        start_if_idle();
        cyc(rb(), ro(), rb(), rb(), mk(1,1,0,0,3'b000,0,0,0,0,0,0));
        cyc(rb(), op,   rb(), rb(), 13'd0);
        case (k)
            0: begin
                cyc(rb(), ro(), rb(), rb(), mk(0,0,0,e,a,0,0,0,0,0,0));
                cyc(run_after, ro(), rb(), rb(), mk(0,0,0,e,a,0,0,0,1,1,0));
            end
            1, 2: begin
                cyc(rb(), ro(), rb(), rb(), mk(0,0,0,0,3'b010,0,0,0,0,0,0));
                for (int i = 0; i < s; i++)
                    cyc(rb(), ro(), rb(), 1'b0, mk(0,0,0,0,3'b010,k==1,k==2,0,0,0,0));
                cyc((k == 2) ? run_after : rb(), ro(), rb(), 1'b1,
                    mk(0,0,0,0,3'b010,k==1,k==2,0,0,k==2,0));
                if (k == 1)
                    cyc(run_after, ro(), rb(), rb(), mk(0,0,0,0,3'b010,0,0,1,1,1,0));
            end
            default: begin
                cyc(run_after, ro(), zb, rb(),
                    mk(0,0,(op == 6'b000100) ? zb : ~zb,0,3'b110,0,0,0,0,1,0));
            end
        endcase
        in_idle = !run_after;
    endtask

    task automatic do_reset(input logic strobe_live);
        mem_ready = 1'b0;
        #1;
        if (strobe_live) begin
            checks++;
            if (mem_write !== 1'b1) begin
                errors++;
                $display("FAIL pre_reset_mem_write got %b exp 1", mem_write);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({dut_v, retired_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset got %b/%0d exp 0/0", dut_v, retired_cnt);
        end
        cnt_m = '0;
        cyc(1'b0, ro(), rb(), rb(), 13'd0);
        reset = 1'b1;
        in_idle = 1'b1;
    endtask

    localparam logic [5:0] LEGAL [11] = '{6'b001000, 6'b001001, 6'b001010, 6'b001100,
                                          6'b001101, 6'b001110, 6'b001111, 6'b100011,
                                          6'b101011, 6'b000100, 6'b000101};

    initial begin
        reset = 1'b0; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
        #1;
        checks++;
        if ({dut_v, retired_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state got %b/%0d exp 0/0", dut_v, retired_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) cyc(1'b0, ro(), rb(), rb(), 13'd0);

        instr(6'b001101, 0, 1'b0, 1'b1);   // ori
        instr(6'b100011, 2, 1'b0, 1'b1);   // lw with 2 stalls
        instr(6'b000100, 0, 1'b1, 1'b1);   // beq taken
        instr(6'b000100, 0, 1'b0, 1'b1);   // beq not taken
        instr(6'b001000, 0, 1'b0, 1'b0);   // addi then idle
        instr(6'b101011, 1, 1'b0, 1'b0);   // sw from idle restart

        for (int n = 0; n < 60; n++)
            instr(LEGAL[$urandom_range(10, 0)], int'($urandom_range(3, 0)), rb(), rb());

        // sw interrupted by reset while mem_write is active
        start_if_idle();
        cyc(rb(), ro(), rb(), rb(), mk(1,1,0,0,3'b000,0,0,0,0,0,0));
        cyc(rb(), 6'b101011, rb(), rb(), 13'd0);
        cyc(rb(), ro(), rb(), rb(), mk(0,0,0,0,3'b010,0,0,0,0,0,0));
        repeat (2) cyc(rb(), ro(), rb(), 1'b0, mk(0,0,0,0,3'b010,0,1,0,0,0,0));
        do_reset(1'b1);
        instr(6'b001111, 0, 1'b0, 1'b1);

        // illegal opcode traps until reset
        cyc(rb(), ro(), rb(), rb(), mk(1,1,0,0,3'b000,0,0,0,0,0,0));
        cyc(rb(), 6'b111111, rb(), rb(), 13'd0);
        repeat (20) cyc(rb(), ro(), rb(), rb(), mk(0,0,0,0,3'b000,0,0,0,0,0,1));
        do_reset(1'b0);
        instr(6'b001110, 0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, ro(), rb(), rb(), 13'd0);

        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
